phase_accumulator: RTL and testbench
====================================

// Module: phase_accumulator
// PURPOSE
//  Sample-rate NCO feeding the waveform stages (square/saw/tri) with a 16-bit phase ramp.
//  Divides i_clk down to the audio sample rate and adds a frequency tuning word (FTW) to a 32-bit accumulator each sample.
//  o_addr is the accumulator MSBs and drives the waveform stage's i_addr directly.
//  FTW load uses a valid/ready handshake and is applied only on sample boundaries (glitch-free pitch change).
// PARAMETERS
//  DIV          1042  i_clk cycles per sample (50 MHz -> ~48 kHz); legal range 2..65535
//  GLIDE_SHIFT  6     glide rate: per-sample step = (target-active)>>>GLIDE_SHIFT (GLIDE only)
// PORTS
//  i_clk          in   1   system clock
//  i_rst          in   1   synchronous, active-high reset
//  i_ftw          in   32  frequency tuning word, f_out = FTW * f_sample / 2^32
//  i_ftw_valid    in   1   i_ftw is valid
//  o_ftw_ready    out  1   block can accept a new FTW
//  i_gate         in   1   note on (1) / off (0); sampled on sample boundaries
//  o_addr         out  16  phase, = acc[31:16]
//  o_sample_valid out  1   1-cycle pulse: o_addr holds a new sample
//  o_wrap         out  1   1-cycle pulse, coincident with o_sample_valid, when acc carried out
// BEHAVIOUR
//  Reset (i_rst=1 at a clk edge): divider=0, tick=0, acc=0, ftw_active=0, ftw_pending=0,
//   o_addr=0, o_sample_valid=0, o_wrap=0, o_ftw_ready=1, state=IDLE. Reset overrides all inputs.
//  Divider: counts 0..DIV-1 and wraps; internal tick=1 for exactly the cycle where count==DIV-1.
//  Sample update, at the clk edge where tick==1:
//   gate_s = i_gate in that cycle. If gate_s==1: {carry,acc} <= acc + ftw_active (33-bit sum, mod 2^32).
//   If gate_s==0: acc <= 0, carry = 0 (phase restarts from 0 at the next note).
//   o_addr <= new acc[31:16]; o_sample_valid <= 1; o_wrap <= carry. Both pulses clear next cycle.
//   Latency: o_addr changes 1 cycle after tick; throughput 1 sample per DIV cycles.
//  FTW handshake FSM (states IDLE, PENDING):
//   IDLE: o_ftw_ready=1. On i_ftw_valid=1: ftw_pending <= i_ftw, go to PENDING.
//   PENDING: o_ftw_ready=0; i_ftw_valid ignored (no capture, no overwrite).
//    At the tick edge: ftw_active <= ftw_pending (the add at this edge uses the OLD ftw_active), go to IDLE.
//   Valid in IDLE in the tick cycle: captured; applied at the NEXT tick, not this one.
//   A word accepted at any point is applied within DIV cycles.
//  Arithmetic: unsigned; wraparound mod 2^32 is intended (carry -> o_wrap).
//   FTW=0 holds phase constant. FTW>=2^31 aliases; not flagged.
//  Reset mid-operation: pending FTW discarded, glide aborted, all state returns to reset values.
// CONFIGURATION
//  Macro PHASE_ACCUMULATOR_GLIDE_EN:
//   Defined: the FSM transfer at the tick loads ftw_target instead of ftw_active.
//    Every tick, ftw_active moves toward ftw_target by d=(target-active)>>>GLIDE_SHIFT (signed 33-bit).
//    If d==0 and target!=active, step is +/-1. It never overshoots, and the new active value is used from the following tick.
//    Reset sets target=0.
//   Undefined: ftw_active is loaded directly (instant pitch change); no glide logic or registers.
// STRUCTURE
//  Shared package synth_pkg: ACC_W=32, ADDR_W=16, and typedef enum {IDLE, PENDING} ftw_state_t.
//  Sub-module sample_tick_gen (parameter DIV; ports i_clk, i_rst, o_tick) holds the divider.
//  FSM, accumulator and glide logic are in this module.
// TESTING (bench uses DIV=4, GLIDE_SHIFT=2)
//  1 Reset: hold i_rst 2 cycles with random inputs -> o_addr=0, o_sample_valid=0, o_wrap=0, o_ftw_ready=1;
//    first o_sample_valid exactly 4 cycles after i_rst falls.
//  2 Ramp: load FTW=0x0100_0000, gate=1 -> o_addr goes 0x0100, 0x0200, ... with one valid per 4 cycles;
//    the 256th sample gives o_addr=0x0000 with o_wrap=1; o_wrap=0 on all other samples.
//  3 Handshake: FTW A accepted, then B held valid -> ready=0 and B ignored until the tick; A takes effect on the
//    sample after that tick; B is accepted once ready=1.
//  4 Gate: gate 1->0 mid-ramp -> next sample o_addr=0, no o_wrap;
//    gate back to 1 with FTW=0x0100_0000 -> o_addr=0x0100.
//  5 Mid-op reset: assert i_rst in PENDING during the tick cycle -> pending discarded, ready=1,
//    o_addr=0, ftw_active=0 (phase stays 0 with gate=1).
//  6 GLIDE_EN build: active=0, target=0x0000_0100 -> per-sample increments 0x40, 0x30, ... converge to exactly 0x100
//    with no overshoot. Non-GLIDE build: the same stimulus gives an immediate 0x100 step.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the synth datapath: accumulator/address widths,
// the FTW handshake state type and the debug view of that handshake.
package synth_pkg;

  localparam int ACC_W  = 32;
  localparam int ADDR_W = 16;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } ftw_state_t;

  // Debug view of the FTW path so checkers can follow the FSM and the tuning words.
  typedef struct packed {
    ftw_state_t         state;
    logic [ACC_W-1:0]   ftw_active;
    logic [ACC_W-1:0]   ftw_target;
  } ftw_dbg_t;

endpackage

// File: rtl/phase_accumulator_if.sv
// FTW load handshake plus the phase/sample outputs of the phase accumulator.
// Handshake: a word on i_ftw transfers at the rising clock edge where
// i_ftw_valid and o_ftw_ready are both 1; while o_ftw_ready is 0 the
// presented word is neither captured nor overwrites anything, and valid may
// be held without penalty.
interface phase_accumulator_if;

  logic [synth_pkg::ACC_W-1:0]  i_ftw;
  logic                         i_ftw_valid;
  logic                         o_ftw_ready;
  logic                         i_gate;
  logic [synth_pkg::ADDR_W-1:0] o_addr;
  logic                         o_sample_valid;
  logic                         o_wrap;

  // Side that drives FTW/gate and consumes the phase.
  modport master (
    output i_ftw, i_ftw_valid, i_gate,
    input  o_ftw_ready, o_addr, o_sample_valid, o_wrap
  );

  // The phase accumulator itself.
  modport slave (
    input  i_ftw, i_ftw_valid, i_gate,
    output o_ftw_ready, o_addr, o_sample_valid, o_wrap
  );

endinterface

// File: rtl/phase_accumulator_sample_tick_gen.sv
// Sample-rate divider: counts 0..DIV-1 and raises o_tick for exactly the
// cycle in which the count sits at DIV-1.
module sample_tick_gen #(
  parameter int DIV = 1042
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  logic [15:0] count;
  logic        at_end;

  assign at_end = (count == 16'(DIV - 1));
  assign o_tick = at_end;

  // Free-running divider, restarted by reset and on reaching DIV-1.
  always_ff @(posedge i_clk) begin
    if (i_rst || at_end) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/phase_accumulator.sv
// Sample-rate NCO: adds the active frequency tuning word to a 32-bit phase
// accumulator once per sample tick and presents the top 16 bits as o_addr.
// New tuning words are taken through a valid/ready handshake and only
// applied on a sample tick, so pitch changes never glitch mid-sample.
// Optional feature macro PHASE_ACCUMULATOR_GLIDE_EN: when defined, a loaded
// word becomes a glide target that the active word approaches each sample.
module phase_accumulator
  import synth_pkg::*;
#(
  parameter int DIV         = 1042,
  parameter int GLIDE_SHIFT = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  phase_accumulator_if.slave  bus,
  output ftw_dbg_t            o_dbg
);

  // Parameter sanity: divider needs at least two cycles, shift must fit the word.
  if (DIV < 2 || DIV > 65535) begin : g_bad_div
    $error("phase_accumulator: DIV must be in 2..65535");
  end
  if (GLIDE_SHIFT < 1 || GLIDE_SHIFT > ACC_W) begin : g_bad_glide_shift
    $error("phase_accumulator: GLIDE_SHIFT must be in 1..ACC_W");
  end

  logic             tick;
  ftw_state_t       state;
  ftw_state_t       state_nxt;
  logic             ftw_ready;
  logic [ACC_W-1:0] ftw_pending;
  logic [ACC_W-1:0] ftw_active;
  logic [ACC_W-1:0] ftw_target;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  // FTW handshake state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: accept a word when idle, hand it over at the next sample tick.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_ftw_valid) state_nxt = PENDING;
      PENDING: if (tick)            state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Handshake outputs: ready only while no word is waiting for a tick.
  always_comb begin
    ftw_ready = 1'b0;
    if (state == IDLE) ftw_ready = 1'b1;
  end

  assign bus.o_ftw_ready = ftw_ready;

  // Hold the accepted word until the sample tick applies it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ftw_pending <= '0;
    end else if (ftw_ready && bus.i_ftw_valid) begin
      ftw_pending <= bus.i_ftw;
    end
  end

`ifdef PHASE_ACCUMULATOR_GLIDE_EN
  logic signed [ACC_W:0] glide_diff;
  logic signed [ACC_W:0] glide_d;
  logic signed [ACC_W:0] glide_step;

  // Glide step: a fixed fraction of the remaining distance, at least one LSB.
  // Arithmetic shift never grows the magnitude, so the step cannot overshoot.
  always_comb begin
    glide_diff = $signed({1'b0, ftw_target}) - $signed({1'b0, ftw_active});
    glide_d    = glide_diff >>> GLIDE_SHIFT;
    glide_step = glide_d;
    if (glide_d == '0 && glide_diff != '0) begin
      glide_step = glide_diff[ACC_W] ? {(ACC_W+1){1'b1}} : {{ACC_W{1'b0}}, 1'b1};
    end
  end

  // Per-tick glide of the active word and hand-over of a pending word as new target.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ftw_active <= '0;
      ftw_target <= '0;
    end else if (tick) begin
      ftw_active <= ftw_active + glide_step[ACC_W-1:0];
      if (state == PENDING) ftw_target <= ftw_pending;
    end
  end
`else
  // Instant pitch change: the pending word becomes active at the tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ftw_active <= '0;
    end else if (tick && state == PENDING) begin
      ftw_active <= ftw_pending;
    end
  end

  assign ftw_target = ftw_active;
`endif

  // The add at a tick edge always uses the word active before that edge.
  assign sum = {1'b0, acc} + {1'b0, ftw_active};

  // Sample update: advance (gate on) or restart (gate off) the phase at each tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc                <= '0;
      bus.o_addr         <= '0;
      bus.o_sample_valid <= 1'b0;
      bus.o_wrap         <= 1'b0;
    end else begin
      bus.o_sample_valid <= 1'b0;
      bus.o_wrap         <= 1'b0;
      if (tick) begin
        bus.o_sample_valid <= 1'b1;
        if (bus.i_gate) begin
          acc        <= sum[ACC_W-1:0];
          bus.o_addr <= sum[ACC_W-1:ACC_W-ADDR_W];
          bus.o_wrap <= sum[ACC_W];
        end else begin
          acc        <= '0;
          bus.o_addr <= '0;
        end
      end
    end
  end

  // Debug view of the handshake FSM and tuning words.
  always_comb begin
    o_dbg            = '0;
    o_dbg.state      = state;
    o_dbg.ftw_active = ftw_active;
    o_dbg.ftw_target = ftw_target;
  end

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator (DIV=4, GLIDE_SHIFT=2).
// Reference model works per sample from the behavioural rules with longint
// arithmetic and a queue of accepted words; samples go through exp_q.
module tb_phase_accumulator;
  import synth_pkg::*;

  localparam int DIV = 4;
  localparam int GS  = 2;

  logic     clk;
  logic     rst;
  ftw_dbg_t dbg;

  phase_accumulator_if bus();

  phase_accumulator #(.DIV(DIV), .GLIDE_SHIFT(GS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus),
    .o_dbg (dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and counters
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [16:0] exp_q[$];
  logic [31:0] pend_q[$];

  // Reference model state
  int     m_cnt    = 0;
  longint m_acc    = 0;
  longint m_active = 0;
  longint m_target = 0;
  logic [15:0] m_addr = '0;
  bit     m_valid  = 1'b0;
  bit     m_wrap   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Glide toward t by floor((t-a)/2^GS), at least one step while not there.
  function automatic longint glide(input longint a, input longint t);
    longint diff, den, d;
    den  = longint'(1) << GS;
    diff = t - a;
    if (diff >= 0) d = diff / den;
    else           d = -((-diff + den - 1) / den);
    if (d == 0 && diff != 0) d = (diff > 0) ? 1 : -1;
    return a + d;
  endfunction

  // Behavioural update for one clock edge with the given inputs.
  task automatic mdl(input bit r, input bit v, input logic [31:0] f, input bit g);
    longint s;
    bit     tick, rdy;
    if (r) begin
      m_cnt = 0; m_acc = 0; m_active = 0; m_target = 0;
      m_addr = '0; m_valid = 1'b0; m_wrap = 1'b0;
      pend_q.delete();
      return;
    end
    tick    = (m_cnt == DIV - 1);
    rdy     = (pend_q.size() == 0);
    m_valid = 1'b0;
    m_wrap  = 1'b0;
    if (tick) begin
      m_valid = 1'b1;
      if (g) begin
        s      = m_acc + m_active;
        m_wrap = (s >= 64'h1_0000_0000);
        m_acc  = s % 64'h1_0000_0000;
      end else begin
        m_acc = 0;
      end
      m_addr = 16'(m_acc / 65536);
      exp_q.push_back({m_wrap, m_addr});
`ifdef PHASE_ACCUMULATOR_GLIDE_EN
      m_active = glide(m_active, m_target);
      if (pend_q.size() != 0) m_target = longint'(pend_q.pop_front());
`else
      if (pend_q.size() != 0) m_active = longint'(pend_q.pop_front());
`endif
    end
    if (rdy && v) pend_q.push_back(f);
    m_cnt = (m_cnt + 1) % DIV;
  endtask

  // Driver: apply inputs for one cycle, step the model, check at the falling edge.
  task automatic cyc(input bit r, input bit v, input logic [31:0] f, input bit g);
    logic [16:0] e;
    rst = r; bus.i_ftw_valid = v; bus.i_ftw = f; bus.i_gate = g;
    @(posedge clk);
    mdl(r, v, f, g);
    @(negedge clk);
    chk("valid", 64'(bus.o_sample_valid), 64'(m_valid));
    chk("addr", 64'(bus.o_addr), 64'(m_addr));
    chk("ready", 64'(bus.o_ftw_ready), 64'(pend_q.size() == 0));
    chk("state", 64'(dbg.state), (pend_q.size() != 0) ? 64'(PENDING) : 64'(IDLE));
    chk("ftw_active", 64'(dbg.ftw_active), 64'(m_active));
    if (m_valid) begin
      e = exp_q.pop_front();
      chk("sample", {47'd0, bus.o_wrap, bus.o_addr}, {47'd0, e});
    end else begin
      chk("wrap_idle", 64'(bus.o_wrap), 64'd0);
    end
  endtask

  int          first;
  int          n_samp;
  int          wraps;
  logic [15:0] wrap_addr;
  logic [15:0] first_nz;
  longint      e_act;
  logic [31:0] ftw_a, ftw_b;
  bit          nz_seen;
  logic [31:0] prev, max_act, inc1, inc2;
  int          n_inc;

  initial begin
    rst = 1'b1; bus.i_ftw = '0; bus.i_ftw_valid = 1'b0; bus.i_gate = 1'b0;
    @(negedge clk);

    // 1: reset with random inputs, then latency of the first sample
    repeat (2) cyc(1'b1, 1'($urandom), $urandom, 1'($urandom));
    chk("rst_addr", 64'(bus.o_addr), 64'd0);
    chk("rst_valid", 64'(bus.o_sample_valid), 64'd0);
    chk("rst_wrap", 64'(bus.o_wrap), 64'd0);
    chk("rst_ready", 64'(bus.o_ftw_ready), 64'd1);
    first = 0;
    for (int i = 1; i <= 2 * DIV && first == 0; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b0);
      if (bus.o_sample_valid) first = i;
    end
    chk("first_valid_latency", 64'(first), 64'd4);

    // 2: ramp with FTW 0x0100_0000
    cyc(1'b0, 1'b1, 32'h0100_0000, 1'b1);
    n_samp = 0; wraps = 0; wrap_addr = 16'hFFFF; first_nz = '0;
    for (int i = 0; i < 270 * DIV; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1);
      if (bus.o_sample_valid) begin
        n_samp++;
        if (bus.o_wrap) begin wraps++; wrap_addr = bus.o_addr; end
        if (first_nz == 0 && bus.o_addr != 0) first_nz = bus.o_addr;
      end
    end
    chk("ramp_sample_count", 64'(n_samp), 64'd270);
    chk("ramp_wrap_count", 64'(wraps), 64'd1);
`ifdef PHASE_ACCUMULATOR_GLIDE_EN
    chk("ramp_first_step", 64'(first_nz), 64'h0040);
`else
    chk("ramp_first_step", 64'(first_nz), 64'h0100);
    chk("ramp_wrap_addr", 64'(wrap_addr), 64'h0000);
`endif

    // 3: handshake, A accepted then B held valid while pending
    ftw_a = $urandom; ftw_b = $urandom;
    cyc(1'b0, 1'b1, ftw_a, 1'b1);
    chk("hs_state_pending", 64'(dbg.state), 64'(PENDING));
    chk("hs_ready_low", 64'(bus.o_ftw_ready), 64'd0);
    for (int i = 0; i < 2 * DIV && !bus.o_ftw_ready; i++) cyc(1'b0, 1'b1, ftw_b, 1'b1);
    chk("hs_ready_back", 64'(bus.o_ftw_ready), 64'd1);
    chk("hs_a_applied", 64'(dbg.ftw_target), 64'(ftw_a));
    cyc(1'b0, 1'b1, ftw_b, 1'b1);
    chk("hs_b_pending", 64'(dbg.state), 64'(PENDING));
    repeat (2 * DIV) cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("hs_b_applied", 64'(dbg.ftw_target), 64'(ftw_b));

    // 4: gate off mid-ramp, then back on
    cyc(1'b0, 1'b1, 32'h0100_0000, 1'b1);
    repeat (3 * DIV) cyc(1'b0, 1'b0, 32'd0, 1'b1);
    first = 0;
    for (int i = 0; i < 2 * DIV && first == 0; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b0);
      if (bus.o_sample_valid) first = 1;
    end
    chk("gate_off_seen", 64'(first), 64'd1);
    chk("gate_off_addr", 64'(bus.o_addr), 64'd0);
    chk("gate_off_wrap", 64'(bus.o_wrap), 64'd0);
    first = 0; e_act = 0;
    for (int i = 0; i < 2 * DIV && first == 0; i++) begin
      e_act = m_active;
      cyc(1'b0, 1'b0, 32'd0, 1'b1);
      if (bus.o_sample_valid) first = 1;
    end
    chk("gate_on_seen", 64'(first), 64'd1);
    chk("gate_on_addr", 64'(bus.o_addr), 64'(e_act / 65536));

    // 5: reset during the tick cycle while a word is pending
    cyc(1'b0, 1'b1, $urandom | 32'h1, 1'b1);
    for (int i = 0; i < 2 * DIV && m_cnt != DIV - 1; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("mid_rst_pending", 64'(dbg.state), 64'(PENDING));
    cyc(1'b1, 1'b1, $urandom, 1'b1);
    chk("mid_rst_ready", 64'(bus.o_ftw_ready), 64'd1);
    chk("mid_rst_addr", 64'(bus.o_addr), 64'd0);
    chk("mid_rst_active", 64'(dbg.ftw_active), 64'd0);
    nz_seen = 1'b0;
    repeat (3 * DIV) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1);
      if (bus.o_addr != 0) nz_seen = 1'b1;
    end
    chk("mid_rst_phase_held", 64'(nz_seen), 64'd0);

    // 6: step from active=0 to 0x100
    cyc(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    prev = dbg.ftw_active; max_act = prev; inc1 = '0; inc2 = '0; n_inc = 0;
    repeat (40 * DIV) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1);
      if (dbg.ftw_active != prev) begin
        n_inc++;
        if (n_inc == 1) inc1 = dbg.ftw_active - prev;
        if (n_inc == 2) inc2 = dbg.ftw_active - prev;
        if (dbg.ftw_active > max_act) max_act = dbg.ftw_active;
        prev = dbg.ftw_active;
      end
    end
`ifdef PHASE_ACCUMULATOR_GLIDE_EN
    chk("glide_inc1", 64'(inc1), 64'h40);
    chk("glide_inc2", 64'(inc2), 64'h30);
`else
    chk("step_inc1", 64'(inc1), 64'h100);
    chk("step_inc2", 64'(inc2), 64'h0);
`endif
    chk("glide_no_overshoot", 64'(max_act), 64'h100);
    chk("glide_final", 64'(dbg.ftw_active), 64'h100);

    // Randomized traffic: sparse resets, random words and gate
    repeat (400) begin
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) == 0),
          $urandom, 1'($urandom_range(0, 7) != 0));
    end
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
